// File: rtl/sbox_byte_sequencer_if.sv
// Handshake and S-box bus for sbox_byte_sequencer.
//  in_valid/in_ready/in_data    : upstream word, byte 0 in the MSBs
//  sbox_u/sbox_u_vld/sbox_s     : byte-serial link to an external AES S-box
//  out_valid/out_ready/out_data : substituted word, same lane order as in_data
// slave  = sequencer side, master = environment side (word source/sink and S-box).
interface sbox_byte_sequencer_if #(
   parameter int unsigned NBYTES = 16
);
   logic                in_valid;
   logic                in_ready;
   logic [8*NBYTES-1:0] in_data;
   logic [7:0]          sbox_u;
   logic                sbox_u_vld;
   logic [7:0]          sbox_s;
   logic                out_valid;
   logic                out_ready;
   logic [8*NBYTES-1:0] out_data;

   modport slave (
      input  in_valid, in_data, sbox_s, out_ready,
      output in_ready, sbox_u, sbox_u_vld, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, sbox_s, out_ready,
      input  in_ready, sbox_u, sbox_u_vld, out_valid, out_data
   );
endinterface

// File: rtl/sbox_byte_sequencer.sv
// Byte-serial wrapper around an external 8-bit AES S-box (SubBytes / SubWord).
// Accepts one NBYTES-wide word, issues its bytes one per cycle on sbox_u, collects
// each sbox_s result SBOX_LAT cycles later into the original lane, then offers the
// substituted word downstream. One word in flight at a time.
//  clk  : rising-edge clock
//  rst  : asynchronous active-high reset
//  clr  : synchronous abort, discards the word in flight
//  bus  : handshake + S-box link (slave modport)
//  busy : high whenever the sequencer is not idle
module sbox_byte_sequencer #(
   parameter int unsigned NBYTES   = 16,
   parameter int unsigned SBOX_LAT = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr,
   sbox_byte_sequencer_if.slave        bus,
   output logic                        busy
);

   localparam int unsigned    IW         = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0]  LAST_IDX   = IW'(NBYTES - 1);
   localparam logic [1:0]     DRAIN_LAST = 2'((SBOX_LAT > 0) ? SBOX_LAT - 1 : 0);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FEED  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]          state_q, state_d;
   logic [IW-1:0]       issue_idx_q, issue_idx_d;
   logic [1:0]          drain_cnt_q, drain_cnt_d;
   logic [8*NBYTES-1:0] word_q, word_d;
   logic [7:0]          sbox_u_q, sbox_u_d;
   logic                rdy_en_q, rdy_en_d;

   logic                in_ready;
   logic                issue_vld;
   logic [7:0]          issue_byte;
   logic                cap_vld;
   logic [IW-1:0]       cap_idx;

   assign issue_vld = (state_q == ST_FEED);
   // in_ready stays low through reset and rises on the first edge after release
   assign rdy_en_d  = 1'b1;
   assign in_ready  = rdy_en_q && (state_q == ST_IDLE);

   always_comb begin
      issue_byte = 8'h00;
      for (int k = 0; k < int'(NBYTES); k++) begin
         if (issue_idx_q == IW'(k)) issue_byte = word_q[8*(int'(NBYTES)-1-k) +: 8];
      end
   end

   // Capture lane comes from the issue index carried alongside the S-box latency,
   // so the writeback can never drift from what was actually issued.
   if (SBOX_LAT == 0) begin : g_no_dly
      assign cap_vld = issue_vld;
      assign cap_idx = issue_idx_q;
   end else begin : g_dly
      logic [SBOX_LAT-1:0]         dly_vld_q, dly_vld_d;
      logic [SBOX_LAT-1:0][IW-1:0] dly_idx_q, dly_idx_d;

      always_comb begin
         dly_vld_d = dly_vld_q;
         dly_idx_d = dly_idx_q;
         for (int i = int'(SBOX_LAT) - 1; i > 0; i--) begin
            dly_vld_d[i] = dly_vld_q[i-1];
            dly_idx_d[i] = dly_idx_q[i-1];
         end
         dly_vld_d[0] = issue_vld;
         dly_idx_d[0] = issue_idx_q;
         if (clr) dly_vld_d = '0;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dly_vld_q <= '0;
            dly_idx_q <= '0;
         end else begin
            dly_vld_q <= dly_vld_d;
            dly_idx_q <= dly_idx_d;
         end
      end

      assign cap_vld = dly_vld_q[SBOX_LAT-1];
      assign cap_idx = dly_idx_q[SBOX_LAT-1];
   end

   always_comb begin
      state_d     = state_q;
      issue_idx_d = issue_idx_q;
      drain_cnt_d = drain_cnt_q;
      word_d      = word_q;
      sbox_u_d    = sbox_u_q;

      // One register holds the input word and the results: lane k is read in
      // the cycle after E(k) and only overwritten at E(k+1+SBOX_LAT).
      for (int k = 0; k < int'(NBYTES); k++) begin
         if (cap_vld && (cap_idx == IW'(k))) word_d[8*(int'(NBYTES)-1-k) +: 8] = bus.sbox_s;
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid && in_ready) begin
               word_d      = bus.in_data;
               issue_idx_d = '0;
               state_d     = ST_FEED;
            end
         end
         ST_FEED: begin
            sbox_u_d = issue_byte;
            if (issue_idx_q == LAST_IDX) begin
               issue_idx_d = '0;
               drain_cnt_d = '0;
               state_d     = (SBOX_LAT > 0) ? ST_DRAIN : ST_DONE;
            end else begin
               issue_idx_d = issue_idx_q + IW'(1);
            end
         end
         ST_DRAIN: begin
            if (drain_cnt_q == DRAIN_LAST) begin
               drain_cnt_d = '0;
               state_d     = ST_DONE;
            end else begin
               drain_cnt_d = drain_cnt_q + 2'd1;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort wins over any same-cycle accept, capture or output handshake.
      if (clr) begin
         state_d     = ST_IDLE;
         issue_idx_d = '0;
         drain_cnt_d = '0;
         word_d      = word_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         issue_idx_q <= '0;
         drain_cnt_q <= '0;
         word_q      <= '0;
         sbox_u_q    <= 8'h00;
         rdy_en_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         issue_idx_q <= issue_idx_d;
         drain_cnt_q <= drain_cnt_d;
         word_q      <= word_d;
         sbox_u_q    <= sbox_u_d;
         rdy_en_q    <= rdy_en_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.sbox_u_vld = issue_vld;
   // Outside FEED the link keeps showing the last byte that was issued.
   assign bus.sbox_u     = issue_vld ? issue_byte : sbox_u_q;
   assign bus.out_valid  = (state_q == ST_DONE);
   assign bus.out_data   = word_q;
   assign busy           = (state_q != ST_IDLE);

endmodule
